// File: rtl/reg_sr_pkg.sv
// reg_sr_pkg: shared FSM state type for the shift register
package reg_sr_pkg;
    typedef enum logic [1:0] {S_IDLE, S_SHIFT, S_DONE} shift_state_t;
endpackage

// File: rtl/reg_sr_cell.sv
// reg_sr_cell: one register bit with reset > set > write > shift > hold priority
module reg_sr_cell (
    input  logic clk,
    input  logic global_reset,
    input  logic data,
    input  logic write_enable,
    input  logic set,
    input  logic reset,
    input  logic shift_en,
    input  logic shift_data,
    output logic q
);
    // per-bit controls beat the shift so a bit hit mid-shift takes the control value
    always_ff @(posedge clk)
        if (global_reset || reset) q <= 1'b0;
        else if (set)              q <= 1'b1;
        else if (write_enable)     q <= data;
        else if (shift_en)         q <= shift_data;
endmodule

// File: rtl/reg_sr_shift.sv
// reg_sr_shift: per-bit controlled register with WIDTH-bit serial shift; REG_SR_SHIFT_PARITY_EN adds a parity output
module reg_sr_shift
    import reg_sr_pkg::*;
#(
    parameter int WIDTH     = 8,
    parameter bit MSB_FIRST = 1
) (
    input  logic             clk,
    input  logic             global_reset,
    input  logic [WIDTH-1:0] data,
    input  logic [WIDTH-1:0] write_enable,
    input  logic [WIDTH-1:0] set,
    input  logic [WIDTH-1:0] reset,
    input  logic             shift_start,
    input  logic             serial_in,
    output logic [WIDTH-1:0] out,
    output logic             serial_out,
    output logic             shift_busy,
    output logic             shift_done
`ifdef REG_SR_SHIFT_PARITY_EN
    ,output logic            parity
`endif
);
    localparam int CW = $clog2(WIDTH + 1);
    shift_state_t state, state_nx;
    logic [CW-1:0] cnt, cnt_nx;
    logic [WIDTH-1:0] shifted;
    logic shift_en;
    assign shift_en   = state == S_SHIFT;
    assign shift_busy = state == S_SHIFT;
    assign shift_done = state == S_DONE;
    assign serial_out = MSB_FIRST ? out[WIDTH-1] : out[0];
    assign shifted    = MSB_FIRST ? {out[WIDTH-2:0], serial_in} : {serial_in, out[WIDTH-1:1]};
`ifdef REG_SR_SHIFT_PARITY_EN
    assign parity = ^out;
`endif
    for (genvar i = 0; i < WIDTH; i++) begin : g_cell
        reg_sr_cell u_cell (
            .clk          (clk),
            .global_reset (global_reset),
            .data         (data[i]),
            .write_enable (write_enable[i]),
            .set          (set[i]),
            .reset        (reset[i]),
            .shift_en     (shift_en),
            .shift_data   (shifted[i]),
            .q            (out[i])
        );
    end
    // state and bit counter registers
    always_ff @(posedge clk)
        if (global_reset) begin
            state <= S_IDLE;
            cnt   <= '0;
        end else begin
            state <= state_nx;
            cnt   <= cnt_nx;
        end
    // start only from idle; leave shifting on the edge doing the WIDTH-th shift
    always_comb begin
        state_nx = state;
        cnt_nx   = cnt;
        case (state)
            S_IDLE: if (shift_start) begin
                state_nx = S_SHIFT;
                cnt_nx   = '0;
            end
            S_SHIFT: begin
                cnt_nx   = cnt + CW'(1);
                state_nx = cnt == CW'(WIDTH - 1) ? S_DONE : S_SHIFT;
            end
            default: state_nx = S_IDLE;
        endcase
    end
endmodule

// File: doc/reg_sr_shift.md
REG_SR_SHIFT -- requirements
Module: reg_sr_shift

Interface
REQ-001 Parameter WIDTH, default 8, register width in bits; legal range 2..64.
REQ-002 Parameter MSB_FIRST, default 1, shift direction: 1 shifts toward MSB, 0 shifts toward LSB.
REQ-003 clk  input  1  single clock; all state SHALL update on its rising edge.
REQ-004 global_reset  input  1  synchronous, active-high reset.
REQ-005 data  input  WIDTH  parallel write data.
REQ-006 write_enable  input  WIDTH  per-bit write enable.
REQ-007 set  input  WIDTH  per-bit set to 1.
REQ-008 reset  input  WIDTH  per-bit clear to 0.
REQ-009 shift_start  input  1  request a WIDTH-bit serial shift.
REQ-010 serial_in  input  1  bit shifted into the vacated end.
REQ-011 out  output  WIDTH  register contents.
REQ-012 serial_out  output  1  bit that leaves on the next shift edge.
REQ-013 shift_busy  output  1  high while shifting.
REQ-014 shift_done  output  1  one-cycle pulse when a shift completes.

Function
REQ-015 Per-bit next-value priority SHALL be: global_reset -> 0; reset[i] -> 0; set[i] -> 1; write_enable[i] -> data[i]; shift active -> shifted neighbour; otherwise hold.
REQ-016 Per-bit controls SHALL take effect on the first rising edge after assertion (1-cycle latency).
REQ-017 The FSM SHALL have states S_IDLE, S_SHIFT and S_DONE.
REQ-018 S_IDLE -> S_SHIFT on an edge with shift_start=1; the bit counter loads 0.
REQ-019 In S_SHIFT, every edge SHALL shift out by one position, insert serial_in at the vacated end (LSB if MSB_FIRST=1, else MSB) and increment the counter.
REQ-020 S_SHIFT -> S_DONE on the edge performing the WIDTH-th shift; S_DONE -> S_IDLE unconditionally on the next edge.
REQ-021 shift_busy SHALL be 1 exactly in S_SHIFT; shift_done SHALL be 1 exactly in S_DONE.
REQ-022 serial_out SHALL combinationally equal out[WIDTH-1] (MSB_FIRST=1) or out[0] (MSB_FIRST=0) in every state.
REQ-023 shift_start SHALL be ignored in S_SHIFT and S_DONE; no request is queued.
REQ-024 When a per-bit control hits a bit during a shift edge, that bit SHALL take the control value, the other bits SHALL shift, and the counter SHALL still advance.
REQ-025 The counter SHALL be $clog2(WIDTH+1) bits wide and SHALL never wrap within one shift.

Reset
REQ-026 global_reset SHALL override all inputs on the same edge.
REQ-027 global_reset SHALL force out=0, state=S_IDLE, counter=0, shift_busy=0 and shift_done=0.
REQ-028 global_reset asserted mid-shift SHALL abort the shift with no shift_done pulse.
REQ-029 There SHALL be no asynchronous reset path.

Configuration
REQ-030 With REG_SR_SHIFT_PARITY_EN defined, an output port parity (1 bit) SHALL equal the XOR of all bits of out (combinational, follows out).
REQ-031 Without REG_SR_SHIFT_PARITY_EN, the parity port and its logic SHALL be absent.
REQ-032 All other behaviour SHALL be identical with and without the macro.

Structure
REQ-033 Package reg_sr_pkg SHALL hold typedef enum shift_state_t {S_IDLE, S_SHIFT, S_DONE} and any shared width constants.
REQ-034 Sub-module reg_sr_cell SHALL implement one bit with the priority of REQ-015, taking an extra shift_en/shift_data pair.
REQ-035 reg_sr_shift SHALL instantiate WIDTH reg_sr_cell instances with a generate loop and contain the FSM and counter.

Verification (WIDTH=8, MSB_FIRST=1)
REQ-036 Reset: global_reset=1 for 1 cycle -> out=0x00, shift_busy=0, shift_done=0, serial_out=0.
REQ-037 Write then conflict: write_enable=0xFF, data=0xA5 -> out=0xA5; next, set=0x01 with reset=0x01 -> out=0xA4 (reset wins).
REQ-038 Full shift: out=0xA5, serial_in=0, shift_start pulse -> serial_out sequence 1,0,1,0,0,1,0,1 over 8 busy cycles; shift_done high the cycle after the 8th shift; final out=0x00.
REQ-039 Mid-shift events: shift_start re-pulsed during busy -> ignored, exactly 8 shifts occur; set=0x01 on the 3rd shift edge -> bit0=1 after that edge, and the shift still completes at the 8th shift.
REQ-040 Abort: global_reset on the 4th shift edge -> out=0x00, S_IDLE, no shift_done pulse.
REQ-041 Parity (macro defined): out=0x07 -> parity=1; out=0x03 -> parity=0.
